// File: rtl/sdr_qsram_banked_ctrl.sv
// ---------------------------------------------------------------------------
// sdr_qsram_banked_ctrl
//
// Banked SDR quad-SRAM controller/model. A DEPTH-word array is interleaved
// across BANKS banks (bank = low address bits) and is accessed through a
// shared tri-state data bus. Reads return through a READ_LATENCY-deep
// pipeline. Consecutive commands to the same bank stall one cycle. A refresh
// scheduler runs every REFRESH_INTERVAL cycles or on a forced Refresh pulse,
// draining outstanding reads before entering REFRESH for REFRESH_CYCLES.
//
// Optional feature macro: QSRAM_PARITY_EN
//   defined     -> every word carries an even-parity bit checked on readout
//   not defined -> no parity storage, parity_error tied low
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   enable         command strobe
//   read           read command
//   write          write command
//   refresh        forced-refresh request (single-cycle pulse)
//   address        word address [ADDR_WIDTH-1:0]
//   data           inout bus: write data in, read data out while read_valid
//   accept         command taken this cycle (combinational)
//   read_valid     data carries read data this cycle
//   refresh_active state is REFRESH
//   cmd_error      one-cycle pulse after Enable with Read=Write=1
//   parity_error   read word failed parity (parity build only)
// ---------------------------------------------------------------------------
module sdr_qsram_banked_ctrl #(
    parameter int ADDR_WIDTH       = 10,
    parameter int DATA_WIDTH       = 9,
    parameter int BANKS            = 4,
    parameter int READ_LATENCY     = 2,
    parameter int REFRESH_INTERVAL = 512,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  read,
    input  logic                  write,
    input  logic                  refresh,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  logic [DATA_WIDTH-1:0] data,
    output logic                  accept,
    output logic                  read_valid,
    output logic                  refresh_active,
    output logic                  cmd_error,
    output logic                  parity_error
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int BANK_BITS = $clog2(BANKS);
    localparam int CNT_W     = $clog2(REFRESH_INTERVAL);
    localparam int BUSY_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  REF_LAST  = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(REFRESH_CYCLES - 1);

`ifdef QSRAM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REFRESH_WAIT,
        ST_REFRESH
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        ref_cnt, ref_cnt_next;
    logic [BUSY_W-1:0]       busy_cnt, busy_cnt_next;
    logic                    pending, pending_next;

    logic [WORD_W-1:0]       mem [DEPTH];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [WORD_W-1:0]       pipe_word [READ_LATENCY];

    logic [BANK_BITS-1:0]    bank;
    logic [BANK_BITS-1:0]    last_bank;
    logic                    last_accepted;
    logic                    valid_cmd;
    logic                    same_bank;
    logic                    next_rv;
    logic                    pipe_empty;
    logic [WORD_W-1:0]       write_word;

    assign bank       = address[BANK_BITS-1:0];
    assign valid_cmd  = enable & (read ^ write);
    assign same_bank  = last_accepted & (bank == last_bank);
    assign pipe_empty = ~|pipe_valid;
    assign read_valid = pipe_valid[READ_LATENCY-1];

    // A write must not be taken if read data will occupy the bus in the
    // following cycle; that is the stage one step from the output.
    generate
        if (READ_LATENCY >= 2) begin : g_next_rv
            assign next_rv = pipe_valid[READ_LATENCY-2];
        end else begin : g_next_rv_none
            assign next_rv = 1'b0;
        end
    endgenerate

`ifdef QSRAM_PARITY_EN
    assign write_word   = {^data, data};
    // Even parity over data plus stored parity bit must come out zero.
    assign parity_error = read_valid & (^pipe_word[READ_LATENCY-1]);
`else
    assign write_word   = data;
    assign parity_error = 1'b0;
`endif

    assign data = read_valid ? pipe_word[READ_LATENCY-1][DATA_WIDTH-1:0]
                             : {DATA_WIDTH{1'bz}};

    // State and scheduler registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            ref_cnt  <= '0;
            busy_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_next;
            ref_cnt  <= ref_cnt_next;
            busy_cnt <= busy_cnt_next;
            pending  <= pending_next;
        end
    end

    // Next-state logic and command acceptance. A forced refresh arriving
    // outside RUN is simply ignored, so overlapping requests merge into the
    // refresh already in progress. Accept is masked during reset so the
    // combinational output honours its reset value.
    always_comb begin
        state_next     = state;
        ref_cnt_next   = ref_cnt;
        busy_cnt_next  = busy_cnt;
        pending_next   = pending;
        refresh_active = 1'b0;
        accept         = 1'b0;

        case (state)
            ST_RUN: begin
                if (refresh || (ref_cnt == REF_LAST)) begin
                    pending_next = 1'b1;
                    state_next   = ST_REFRESH_WAIT;
                end else begin
                    ref_cnt_next = ref_cnt + 1'b1;
                end
                accept = ~rst & valid_cmd & ~pending & ~same_bank &
                         ~(write & next_rv);
            end
            ST_REFRESH_WAIT: begin
                if (pipe_empty) begin
                    state_next    = ST_REFRESH;
                    busy_cnt_next = '0;
                    ref_cnt_next  = '0;
                    pending_next  = 1'b0;
                end
            end
            ST_REFRESH: begin
                refresh_active = 1'b1;
                if (busy_cnt == BUSY_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    busy_cnt_next = busy_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Read valid pipeline, same-bank history and command-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid    <= '0;
            last_bank     <= '0;
            last_accepted <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            pipe_valid[0] <= accept & read;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
            last_bank     <= bank;
            last_accepted <= accept;
            cmd_error     <= enable & read & write;
        end
    end

    // Read data pipeline; payload follows the valid bits so needs no reset
    always_ff @(posedge clk) begin
        pipe_word[0] <= mem[address];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_word[i] <= pipe_word[i-1];
        end
    end

    // Array write port; contents survive reset and refresh
    always_ff @(posedge clk) begin
        if (accept && write) begin
            mem[address] <= write_word;
        end
    end

endmodule

// File: tb/tb_sdr_qsram_banked_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdr_qsram_banked_ctrl
//
// Directed testbench for sdr_qsram_banked_ctrl with default parameters
// (READ_LATENCY 2, BANKS 4, REFRESH_INTERVAL 512, REFRESH_CYCLES 4).
// Each applyStimulus call drives one cycle's inputs just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising
// edge. The bus has a weak pull-up so an undriven bus reads as all ones.
// ---------------------------------------------------------------------------
module tb_sdr_qsram_banked_ctrl;

    localparam int AW = 10;
    localparam int DW = 9;
    localparam logic [DW-1:0] BUS_Z = 9'h1FF;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, read, write, refresh;
    logic [AW-1:0] address;
    logic          accept, read_valid, refresh_active, cmd_error, parity_error;
    logic          drv_en;
    logic [DW-1:0] drv_val;
    wire  [DW-1:0] bus;

    int check_count = 0;
    int pass_count  = 0;

    pullup (bus);
    assign bus = drv_en ? drv_val : {DW{1'bz}};

    always #5 clk = ~clk;

    sdr_qsram_banked_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .read           (read),
        .write          (write),
        .refresh        (refresh),
        .address        (address),
        .data           (bus),
        .accept         (accept),
        .read_valid     (read_valid),
        .refresh_active (refresh_active),
        .cmd_error      (cmd_error),
        .parity_error   (parity_error)
    );

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then settle
    task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                                 input logic rf, input logic [AW-1:0] addr,
                                 input logic drive, input logic [DW-1:0] wdata);
        @(negedge clk);
        enable  = en;
        read    = rd;
        write   = wr;
        refresh = rf;
        address = addr;
        drv_en  = drive;
        drv_val = wdata;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic writeCycle(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, addr, 1'b1, wdata);
    endtask

    task automatic readCycle(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, addr, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; read = 1'b1; write = 1'b0; refresh = 1'b0;
        address = 10'd5; drv_en = 1'b0; drv_val = '0;
        #2;
        $display("[TB] reset values");
        checkOutput("rst_accept", accept, 0);
        checkOutput("rst_rv", read_valid, 0);
        checkOutput("rst_bus", bus, BUS_Z);
        checkOutput("rst_ra", refresh_active, 0);
        checkOutput("rst_cmderr", cmd_error, 0);
        checkOutput("rst_parerr", parity_error, 0);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; read = 1'b0;

        $display("[TB] fill array, bank stall on writes");
        writeCycle(10'd5, 9'h1A5); checkOutput("w5_acc", accept, 1);
        writeCycle(10'd6, 9'h0F0); checkOutput("w6_acc", accept, 1);
        writeCycle(10'd9, 9'h0AA); checkOutput("w9_acc", accept, 1);
        writeCycle(10'd4, 9'h033); checkOutput("w4_acc", accept, 1);
        writeCycle(10'd8, 9'h155); checkOutput("w8_stall", accept, 0);
        writeCycle(10'd8, 9'h155); checkOutput("w8_acc", accept, 1);
        idleCycle();

        $display("[TB] back-to-back reads, different banks");
        readCycle(10'd5);
        checkOutput("r5_acc", accept, 1);
        checkOutput("r5_bus_z", bus, BUS_Z);
        readCycle(10'd6);
        checkOutput("r6_acc", accept, 1);
        checkOutput("r6_rv0", read_valid, 0);
        checkOutput("r6_bus_z", bus, BUS_Z);
        idleCycle();
        checkOutput("r5_rv", read_valid, 1);
        checkOutput("r5_data", bus, 9'h1A5);
        checkOutput("r5_par", parity_error, 0);
        idleCycle();
        checkOutput("r6_rv", read_valid, 1);
        checkOutput("r6_data", bus, 9'h0F0);
        idleCycle();
        checkOutput("post_rv0", read_valid, 0);
        checkOutput("post_bus_z", bus, BUS_Z);

        $display("[TB] same-bank reads stall one cycle");
        readCycle(10'd4); checkOutput("r4_acc", accept, 1);
        readCycle(10'd8); checkOutput("r8_stall", accept, 0);
        readCycle(10'd8);
        checkOutput("r8_acc", accept, 1);
        checkOutput("r4_rv", read_valid, 1);
        checkOutput("r4_data", bus, 9'h033);
        idleCycle();
        checkOutput("r4_rv_drop", read_valid, 0);
        idleCycle();
        checkOutput("r8_rv", read_valid, 1);
        checkOutput("r8_data", bus, 9'h155);
        idleCycle();
        checkOutput("r8_rv_drop", read_valid, 0);

        $display("[TB] write blocked by upcoming read data");
        readCycle(10'd9); checkOutput("r9_acc", accept, 1);
        writeCycle(10'd7, 9'h07E); checkOutput("w7_contention", accept, 0);
        idleCycle();
        checkOutput("r9_rv", read_valid, 1);
        checkOutput("r9_data", bus, 9'h0AA);
        idleCycle();

        $display("[TB] read and write together is an error");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd5, 1'b1, 9'h000);
        checkOutput("rw_acc", accept, 0);
        checkOutput("rw_err_early", cmd_error, 0);
        idleCycle(); checkOutput("rw_err_pulse", cmd_error, 1);
        idleCycle(); checkOutput("rw_err_once", cmd_error, 0);
        readCycle(10'd5); checkOutput("r5b_acc", accept, 1);
        idleCycle();
        idleCycle(); checkOutput("r5b_data", bus, 9'h1A5);

        $display("[TB] forced refresh with read in flight");
        readCycle(10'd6); checkOutput("p0_acc", accept, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
        checkOutput("p1_ra", refresh_active, 0);
        readCycle(10'd9);
        checkOutput("p2_acc", accept, 0);
        checkOutput("p2_rv", read_valid, 1);
        checkOutput("p2_data", bus, 9'h0F0);
        checkOutput("p2_ra", refresh_active, 0);
        readCycle(10'd9);
        checkOutput("p3_acc", accept, 0);
        checkOutput("p3_rv", read_valid, 0);
        checkOutput("p3_ra", refresh_active, 0);
        readCycle(10'd9);
        checkOutput("p4_ra", refresh_active, 1);
        checkOutput("p4_acc", accept, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 10'd9, 1'b0, '0);
        checkOutput("p5_ra", refresh_active, 1);
        readCycle(10'd9);
        readCycle(10'd9);
        checkOutput("p7_ra", refresh_active, 1);
        readCycle(10'd9);
        checkOutput("p8_ra", refresh_active, 0);
        checkOutput("p8_acc", accept, 1);
        idleCycle(); checkOutput("p9_ra", refresh_active, 0);
        idleCycle();
        checkOutput("p10_data", bus, 9'h0AA);
        checkOutput("p10_ra", refresh_active, 0);
        idleCycle(); checkOutput("p11_ra", refresh_active, 0);
        idleCycle(); checkOutput("p12_ra", refresh_active, 0);

        $display("[TB] asynchronous reset with read in flight");
        readCycle(10'd5); checkOutput("q0_acc", accept, 1);
        idleCycle();
        idleCycle(); checkOutput("q2_rv", read_valid, 1);
        enable = 1'b1; read = 1'b1; address = 10'd6;
        rst = 1'b1;
        #1;
        checkOutput("q_rst_rv", read_valid, 0);
        checkOutput("q_rst_bus", bus, BUS_Z);
        checkOutput("q_rst_acc", accept, 0);
        checkOutput("q_rst_ra", refresh_active, 0);

        // Cycle 0 is the one in which reset is released; the counter reads k
        // in cycle k and expires after cycle 511.
        $display("[TB] automatic refresh");
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; read = 1'b0; address = '0;
        for (int k = 1; k <= 511; k++) begin
            idleCycle();
        end
        checkOutput("c511_ra", refresh_active, 0);
        readCycle(10'd5);
        checkOutput("c512_acc", accept, 0);
        checkOutput("c512_ra", refresh_active, 0);
        readCycle(10'd5);
        checkOutput("c513_ra", refresh_active, 1);
        checkOutput("c513_acc", accept, 0);
        readCycle(10'd5);
        readCycle(10'd5);
        readCycle(10'd5);
        checkOutput("c516_ra", refresh_active, 1);
        checkOutput("c516_acc", accept, 0);
        readCycle(10'd5);
        checkOutput("c517_ra", refresh_active, 0);
        checkOutput("c517_acc", accept, 1);
        idleCycle();
        idleCycle();
        checkOutput("c519_rv", read_valid, 1);
        checkOutput("c519_data", bus, 9'h1A5);

`ifdef QSRAM_PARITY_EN
        $display("[TB] parity check");
        idleCycle();
        dut.mem[5][0] = ~dut.mem[5][0];
        readCycle(10'd5); checkOutput("par5_acc", accept, 1);
        readCycle(10'd6); checkOutput("par6_acc", accept, 1);
        idleCycle();
        checkOutput("par5_rv", read_valid, 1);
        checkOutput("par5_data", bus, 9'h1A4);
        checkOutput("par5_err", parity_error, 1);
        idleCycle();
        checkOutput("par6_rv", read_valid, 1);
        checkOutput("par6_err", parity_error, 0);
        idleCycle();
        checkOutput("par_idle", parity_error, 0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
